mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed response latency.
// Illegal requests (misaligned or out of range) answer after one cycle with err set.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_next_s;
    logic [AW-1:0]   idx_r;
    logic [31:0]     wdata_r;
    logic            we_r;
    logic            legal_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            in_legal_s;
    logic            accept_s;
    logic [AW-1:0]   t_idx_s;
    logic [31:0]     t_wdata_s;
    logic            t_we_s;
    logic            t_legal_s;
    logic            enter_resp_s;
    logic            wr_en_s;

    // On the accepting edge the transaction is taken straight from the inputs,
    // afterwards only from the captured copy, so mid-transaction input changes are ignored.
    assign in_legal_s   = (adr[1:0] == 2'b00) && (adr < LIMIT);
    assign accept_s     = (state_r == IDLE) && req;
    assign t_idx_s      = (state_r == IDLE) ? adr[AW+1:2] : idx_r;
    assign t_wdata_s    = (state_r == IDLE) ? wdata : wdata_r;
    assign t_we_s       = (state_r == IDLE) ? we : we_r;
    assign t_legal_s    = (state_r == IDLE) ? in_legal_s : legal_r;
    assign enter_resp_s = (state_next_s == RESP);
    assign wr_en_s      = rst & enter_resp_s & t_legal_s & t_we_s;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and counter logic; the counter stops at zero instead of wrapping.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (!in_legal_s || (LATENCY == 0)) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r   <= '0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
            legal_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= adr[AW+1:2];
            wdata_r <= wdata;
            we_r    <= we;
            legal_r <= in_legal_s;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[t_idx_s] <= t_wdata_s;
        end
    end

    // Registered response outputs, all loaded on the edge that enters RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ready <= enter_resp_s;
            err   <= enter_resp_s & ~t_legal_s;
            busy  <= (state_next_s != IDLE);
            if (enter_resp_s) begin
                if (!t_legal_s) begin
                    rdata <= 32'd0;
                end else if (t_we_s) begin
                    rdata <= t_wdata_s;
                end else begin
                    rdata <= mem_r[t_idx_s];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 and one with LATENCY=0,
// both checked against a word-array reference model.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req2, we2, req0, we0;
    logic [31:0] adr2, wdata2, adr0, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        ready2, err2, busy2, ready0, err0, busy0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem2 [256];
    bit          known2 [256];
    logic [31:0] mem0 [256];
    bit          known0 [256];

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .adr(adr2), .wdata(wdata2),
        .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .adr(adr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit d0, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (d0) begin
            req0 = r; we0 = w; adr0 = a; wdata0 = d;
        end else begin
            req2 = r; we2 = w; adr2 = a; wdata2 = d;
        end
    endtask

    // One complete transaction; expectations come from the address rules and the model array.
    task automatic txn(input bit d0, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble);
        bit          illegal;
        int          idx;
        int          lat_exp;
        int          cyc;
        bit          known;
        logic [31:0] exp_rd;
        logic        rdy, bsy, er;
        logic [31:0] rd;
        illegal = (a[1:0] != 2'b00) || (a >= 32'd1024);
        idx     = int'(a[9:2]);
        lat_exp = illegal ? 1 : (d0 ? 1 : 3);
        if (illegal) begin
            exp_rd = 32'd0; known = 1'b1;
        end else if (w) begin
            exp_rd = d; known = 1'b1;
        end else begin
            exp_rd = d0 ? mem0[idx] : mem2[idx];
            known  = d0 ? known0[idx] : known2[idx];
        end
        @(negedge clk);
        drive(d0, 1'b1, w, a, d);
        @(posedge clk);
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 16) begin
            @(negedge clk);
            cyc++;
            rdy = d0 ? ready0 : ready2;
            bsy = d0 ? busy0 : busy2;
            er  = d0 ? err0 : err2;
            rd  = d0 ? rdata0 : rdata2;
            check("busy_during_txn", 32'(bsy), 32'd1);
            if (rdy) drive(d0, 1'b0, 1'($urandom), $urandom, $urandom);
            else if (scramble) drive(d0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            else drive(d0, 1'b0, w, a, d);
        end
        check("ready_seen", 32'(rdy), 32'd1);
        check("latency", 32'(cyc), 32'(lat_exp));
        check("err", 32'(er), 32'(illegal));
        if (known) check("rdata", rd, exp_rd);
        if (!illegal && w) begin
            if (d0) begin mem0[idx] = d; known0[idx] = 1'b1; end
            else begin mem2[idx] = d; known2[idx] = 1'b1; end
        end
        @(negedge clk);
        check("ready_single_pulse", 32'(d0 ? ready0 : ready2), 32'd0);
        check("busy_after_resp", 32'(d0 ? busy0 : busy2), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < 256; i++) begin
            known2[i] = 1'b0;
            known0[i] = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_ready", 32'(ready2), 32'd0);
        check("reset_err", 32'(err2), 32'd0);
        check("reset_busy", 32'(busy2), 32'd0);
        check("reset_rdata", rdata2, 32'd0);
        check("reset_ready_l0", 32'(ready0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Write then read back; the write is accepted on the first edge after reset release.
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Misaligned request leaves word 0x10 alone.
        txn(1'b0, 1'b1, 32'h12, 32'h11111111, 1'b0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Out-of-range write must not alias onto word 0 or word 255.
        txn(1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 1'b0);
        txn(1'b0, 1'b1, 32'h3FC, 32'h5F5F5F5F, 1'b0);
        txn(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
        txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        txn(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0);

        // Inputs toggling during WAIT must not disturb the captured transaction.
        txn(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 1'b1);
        txn(1'b0, 1'b0, 32'h24, 32'h0, 1'b1);

        // Reset in WAIT aborts a write to 0x20.
        txn(1'b0, 1'b1, 32'h20, 32'hA5A50020, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_busy_before", 32'(busy2), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(ready2), 32'd0);
        check("abort_err", 32'(err2), 32'd0);
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_rdata", rdata2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(ready2), 32'd0);
        end
        rst = 1'b1;
        txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);

        // Random traffic on the LATENCY=2 instance.
        for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) a = 32'($urandom_range(0, 15) * 4);
            else if (kind == 7) a = 32'($urandom_range(0, 255) * 4) | 32'($urandom_range(1, 3));
            else a = 32'd1024 + 32'($urandom_range(0, 100000));
            txn(1'b0, 1'($urandom), a, $urandom, 1'($urandom));
        end

        // LATENCY=0 instance: last word, then req held high.
        txn(1'b1, 1'b1, 32'h3FC, 32'h0BADCAFE, 1'b0);
        txn(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        txn(1'b1, 1'b1, 32'h4, 32'h44444444, 1'b0);
        txn(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("held_req_ready", 32'(ready0), 32'(k % 2));
            check("held_req_busy", 32'(busy0), 32'(k % 2));
            if (k % 2 == 1) check("held_req_rdata", rdata0, mem0[255]);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
